seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range CLK_DIV >= BLANK_CYCLES+2.
REQ-002 Parameter BLANK_CYCLES, default 16, anode-off guard cycles at the start of each slot; legal range >= 0.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 DATA_IN  input  16  four display nibbles; [3:0] = rightmost digit 0, [15:12] = leftmost digit 3.
REQ-006 DOT_IN  input  4  decimal-point bits; bit n belongs to digit n.
REQ-007 LOAD  input  1  capture request for DATA_IN/DOT_IN, sampled every cycle.
REQ-008 LOAD_ACK  output  1  one-cycle pulse when captured data becomes the displayed data.
REQ-009 SEG_SELECT  output  2  index of the active digit; feeds the 7-seg decoder select input.
REQ-010 BIN_OUT  output  4  nibble of the active digit; feeds the decoder data input.
REQ-011 DOT_OUT  output  1  dot bit of the active digit, active-high.
REQ-012 BLANK  output  1  high during the guard window; the consumer forces all anodes off.
REQ-013 FRAME_DONE  output  1  one-cycle pulse after digit 3's slot ends.

Function
REQ-014 Slot counter cnt SHALL count 0..CLK_DIV-1 and wrap to 0; width = clog2(CLK_DIV).
REQ-015 Digit register SHALL advance 0->1->2->3->0 on the cycle cnt == CLK_DIV-1; SEG_SELECT SHALL equal the digit register.
REQ-016 BLANK SHALL be high exactly while cnt < BLANK_CYCLES; BLANK_CYCLES = 0 SHALL give BLANK constantly low.
REQ-017 BIN_OUT and DOT_OUT SHALL be selected from the shadow register by the digit register, with no combinational path from any input to any output.
REQ-018 LOAD high SHALL copy DATA_IN/DOT_IN into a pending register and set pending_valid; a later LOAD before commit SHALL overwrite pending (newest wins).
REQ-019 Frame boundary is the cycle where digit == 3 and cnt == CLK_DIV-1; only at that edge SHALL the shadow register update (tear-free).
REQ-020 At the boundary, LOAD high SHALL commit DATA_IN/DOT_IN directly; otherwise pending_valid SHALL commit pending; otherwise the shadow register SHALL hold.
REQ-021 Any commit SHALL clear pending_valid and pulse LOAD_ACK for exactly the one cycle after the boundary edge; at most one ack per frame.
REQ-022 FRAME_DONE SHALL pulse in the same cycle as any LOAD_ACK (the cycle after the boundary edge), every frame, with or without a commit.
REQ-023 One frame SHALL last exactly 4*CLK_DIV cycles; LOAD has no effect on scan timing.

Reset
REQ-024 RESET high at an edge SHALL set cnt=0, digit=0, shadow=0, pending=0, pending_valid=0, LOAD_ACK=0, FRAME_DONE=0.
REQ-025 After reset: SEG_SELECT=0, BIN_OUT=0, DOT_OUT=0, BLANK=1 (if BLANK_CYCLES>0).
REQ-026 RESET SHALL override LOAD and any boundary in the same cycle; data pending at reset SHALL be discarded without an ack.

Structure
REQ-027 Package seg7_pkg SHALL hold NUM_DIGITS=4, NIBBLE_W=4, and the CLK_DIV/BLANK_CYCLES defaults.
REQ-028 Sub-module seg7_slot_timer SHALL own cnt and provide slot_end and blank; digit, shadow and handshake logic stay in seg7_scan_driver.

Verification (CLK_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset: RESET high 3 cycles -> SEG_SELECT=0, BIN_OUT=0, DOT_OUT=0, BLANK=1, LOAD_ACK=0, FRAME_DONE=0.
REQ-030 Scan: commit 0x1234 with DOT_IN=4'b0100 -> successive 8-cycle slots show (0,4,0),(1,3,0),(2,2,1),(3,1,0); BLANK high for cycles 0-1 of each slot.
REQ-031 Tear-free: LOAD 0xABCD during digit 1 -> outputs unchanged until the boundary; LOAD_ACK and FRAME_DONE high together 1 cycle after it; the next frame shows D,C,B,A.
REQ-032 Overwrite: LOAD 0x1111 then 0x2222 in the same frame -> only 0x2222 displayed; exactly one LOAD_ACK.
REQ-033 Coincident: pending 0x5555, LOAD with DATA_IN=0x6666 on the boundary cycle -> 0x6666 committed; one LOAD_ACK; pending_valid cleared.
REQ-034 Reset mid-operation: RESET at digit 2, cnt 5, pending valid -> next cycle all outputs at reset values; no LOAD_ACK in the following frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants and types for the 4-digit multiplexed 7-segment scan
//   driver. The frame_t struct bundles the four display nibbles with their
//   decimal-point bits so the pending and shadow registers move together.
package seg7_pkg;

    localparam int NUM_DIGITS           = 4;
    localparam int NIBBLE_W             = 4;
    localparam int CLK_DIV_DEFAULT      = 50000;
    localparam int BLANK_CYCLES_DEFAULT = 16;

    localparam int DIGIT_W = $clog2(NUM_DIGITS);
    localparam int DATA_W  = NUM_DIGITS * NIBBLE_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] dots;
        logic [DATA_W-1:0]     data;
    } frame_t;

    // Nibble belonging to digit idx; digit 0 is the rightmost (bits [3:0]).
    function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [DATA_W-1:0] d,
                                                      input digit_t            idx);
        return d[idx*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Groups the data-load handshake and the scan outputs of seg7_scan_driver.
//   Handshake: LOAD is a per-cycle capture request with no ready; every
//   cycle LOAD is high the DATA_IN/DOT_IN values are taken (newest wins).
//   LOAD_ACK pulses for one cycle when captured data becomes the displayed
//   data, which only happens right after a frame boundary.
//   slave  : the scan driver (takes DATA_IN/DOT_IN/LOAD, drives the rest)
//   master : the data source / display consumer
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [DATA_W-1:0]     DATA_IN;
    logic [NUM_DIGITS-1:0] DOT_IN;
    logic                  LOAD;
    logic                  LOAD_ACK;
    logic [DIGIT_W-1:0]    SEG_SELECT;
    logic [NIBBLE_W-1:0]   BIN_OUT;
    logic                  DOT_OUT;
    logic                  BLANK;
    logic                  FRAME_DONE;

    modport slave (
        input  DATA_IN, DOT_IN, LOAD,
        output LOAD_ACK, SEG_SELECT, BIN_OUT, DOT_OUT, BLANK, FRAME_DONE
    );

    modport master (
        output DATA_IN, DOT_IN, LOAD,
        input  LOAD_ACK, SEG_SELECT, BIN_OUT, DOT_OUT, BLANK, FRAME_DONE
    );

endinterface

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer
//   Per-digit slot timer. cnt runs 0..CLK_DIV-1 and wraps.
//   Ports:
//     CLK, RESET  : system clock, synchronous active-high reset
//     slot_end_o  : high on the last cycle of a slot (cnt == CLK_DIV-1)
//     blank_o     : high while cnt < BLANK_CYCLES (anode-off guard window)
module seg7_slot_timer #(
    parameter int CLK_DIV      = seg7_pkg::CLK_DIV_DEFAULT,
    parameter int BLANK_CYCLES = seg7_pkg::BLANK_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    output logic slot_end_o,
    output logic blank_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (slot_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero-length guard must not build an always-false compare.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_o = 1'b0;
        end else begin : g_blank
            assign blank_o = (cnt_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes four nibbles (plus dots) onto one 7-seg decoder.
//   New data is staged in a pending register and copied to the displayed
//   shadow register only at the frame boundary (end of digit 3's slot), so a
//   frame never shows a mix of old and new digits.
//   Ports:
//     CLK, RESET : system clock, synchronous active-high reset
//     bus        : DATA_IN/DOT_IN/LOAD in; LOAD_ACK, SEG_SELECT, BIN_OUT,
//                  DOT_OUT, BLANK, FRAME_DONE out (all outputs registered
//                  or decoded from registers only)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    seg7_scan_driver_if.slave   bus
);

    logic   slot_end;
    logic   blank;
    logic   frame_end;
    frame_t in_frame;

    digit_t digit_q,         digit_d;
    frame_t shadow_q,        shadow_d;
    frame_t pending_q,       pending_d;
    logic   pending_valid_q, pending_valid_d;
    logic   load_ack_q,      load_ack_d;
    logic   frame_done_q,    frame_done_d;

    seg7_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .slot_end_o (slot_end),
        .blank_o    (blank)
    );

    assign in_frame  = '{dots: bus.DOT_IN, data: bus.DATA_IN};
    assign frame_end = slot_end && (digit_q == digit_t'(NUM_DIGITS - 1));

    always_comb begin
        digit_d         = digit_q;
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        load_ack_d      = 1'b0;
        frame_done_d    = frame_end;

        if (slot_end) begin
            digit_d = digit_q + 1'b1;
        end

        if (frame_end) begin
            // A LOAD arriving on the boundary is newer than anything pending,
            // so it bypasses the pending register.
            if (bus.LOAD) begin
                shadow_d        = in_frame;
                pending_valid_d = 1'b0;
                load_ack_d      = 1'b1;
            end else if (pending_valid_q) begin
                shadow_d        = pending_q;
                pending_valid_d = 1'b0;
                load_ack_d      = 1'b1;
            end
        end else if (bus.LOAD) begin
            pending_d       = in_frame;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            digit_q         <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            load_ack_q      <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            digit_q         <= digit_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            load_ack_q      <= load_ack_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign bus.SEG_SELECT = digit_q;
    assign bus.BIN_OUT    = nibble_of(shadow_q.data, digit_q);
    assign bus.DOT_OUT    = shadow_q.dots[digit_q];
    assign bus.BLANK      = blank;
    assign bus.LOAD_ACK   = load_ack_q;
    assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with CLK_DIV=8, BLANK_CYCLES=2.
//   The bench keeps its own cycle position since reset; loads push the
//   expected {dots,data} word to exp_q (newest overwrites an uncommitted
//   tail) and the word is popped at the frame boundary, after which every
//   digit slot is compared against it.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * CLK_DIV;

    logic clk;
    logic rst;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          pend  = 1'b0;
    logic [19:0] disp  = '0;
    logic [19:0] exp_q[$];

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: log any load into the scoreboard, step the edge, update the
    // expected position/display, then compare every output.
    task automatic tick();
        bit was_rst  = rst;
        bit boundary = ((cyc % FRAME) == FRAME - 1);
        bit exp_ack  = 1'b0;
        int d;
        int c;
        if (!was_rst && bus.LOAD) begin
            if (pend) begin
                exp_q[exp_q.size()-1] = {bus.DOT_IN, bus.DATA_IN};
            end else begin
                exp_q.push_back({bus.DOT_IN, bus.DATA_IN});
                pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            cyc  = 0;
            disp = '0;
            pend = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (boundary && pend) begin
                disp    = exp_q.pop_front();
                pend    = 1'b0;
                exp_ack = 1'b1;
            end
        end
        d = (cyc / CLK_DIV) % 4;
        c = cyc % CLK_DIV;
        chk("seg_select", 20'(bus.SEG_SELECT), 20'(d));
        chk("bin_out",    20'(bus.BIN_OUT),    20'((disp[15:0] >> (4 * d)) & 16'hF));
        chk("dot_out",    20'(bus.DOT_OUT),    20'(disp[16 + d]));
        chk("blank",      20'(bus.BLANK),      20'(c < BLANK_CYCLES));
        chk("load_ack",   20'(bus.LOAD_ACK),   20'(exp_ack));
        chk("frame_done", 20'(bus.FRAME_DONE), 20'(!was_rst && boundary));
    endtask

    // driver tasks
    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic advance_to(input int pos);
        for (int i = 0; i < FRAME; i++) begin
            if ((cyc % FRAME) == pos) break;
            tick();
        end
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dots);
        bus.DATA_IN = data;
        bus.DOT_IN  = dots;
        bus.LOAD    = 1'b1;
        tick();
        bus.LOAD    = 1'b0;
    endtask

    initial begin
        bus.DATA_IN = '0;
        bus.DOT_IN  = '0;
        bus.LOAD    = 1'b0;
        rst         = 1'b1;

        // reset held three cycles, with a load attempt that must be ignored
        tick();
        bus.LOAD = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        tick();
        rst = 1'b0;

        // basic scan of 0x1234, dot on digit 2
        load(16'h1234, 4'b0100);
        advance_to(FRAME - 1);
        run(FRAME + 1);

        // tear-free update requested during digit 1
        advance_to(CLK_DIV + 3);
        load(16'hABCD, 4'b0000);
        advance_to(FRAME - 1);
        run(FRAME + 1);

        // overwrite inside one frame: only the second value shows
        advance_to(2);
        load(16'h1111, 4'b1111);
        advance_to(20);
        load(16'h2222, 4'b0010);
        advance_to(FRAME - 1);
        run(FRAME + 1);

        // pending value overtaken by a load on the boundary cycle itself
        advance_to(10);
        load(16'h5555, 4'b0000);
        advance_to(FRAME - 1);
        load(16'h6666, 4'b1001);
        run(FRAME + 1);

        // reset at digit 2, cnt 5 with data pending: no ack may follow
        advance_to(5);
        load(16'h7777, 4'b1111);
        advance_to(2 * CLK_DIV + 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * FRAME);

        // random loads at random positions
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(1, 40));
            load(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
        end
        run(2 * FRAME + 1);

        chk("queue_empty", 20'(exp_q.size()), 20'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
